// File: rtl/pe_cmd_sched.sv
// pe_cmd_sched: round-robin arbitration of two command requesters onto one serial PE command line,
// with per-opcode execute windows and an inter-frame gap.
module pe_cmd_sched #(
    parameter int EXEC_SHORT = 32,
    parameter int EXEC_LONG  = 128,
    parameter int GAP        = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       req0,
    input  logic [7:0] addr0,
    input  logic [2:0] op0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] addr1,
    input  logic [2:0] op1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       res_window,
    output logic       grant_id
);
    localparam int MAXC = (EXEC_LONG > 8) ? EXEC_LONG : 8;
    localparam int MAXA = (MAXC > GAP) ? MAXC : GAP;
    localparam int CW   = $clog2(MAXA);
    localparam logic [CW-1:0] C_BIT   = CW'(7);
    localparam logic [CW-1:0] C_SHORT = CW'(EXEC_SHORT - 1);
    localparam logic [CW-1:0] C_LONG  = CW'(EXEC_LONG - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_CMD, S_EXEC, S_GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    addr_q, addr_n;
    logic [2:0]    op_q, op_n;
    logic          last_grant, last_n, gid_n, ack0_n, ack1_n;
    logic          win, long_op;
    logic [7:0]    cmd;
    logic [2:0]    bit_idx;

    // A lone requester wins; under contention the one not granted last time wins.
    assign win        = req1 & (~req0 | ~last_grant);
    assign long_op    = (op_q == 3'h2) || (op_q == 3'h3);
    assign cmd        = {4'b0000, op_q, 1'b0};
    assign bit_idx    = 3'd7 - cnt[2:0];
    assign busy       = state != S_IDLE;
    assign res_window = (state == S_EXEC) && long_op;
    assign tx         = (state == S_START) ? 1'b0 :
                        (state == S_ADDR)  ? addr_q[bit_idx] :
                        (state == S_CMD)   ? cmd[bit_idx] : 1'b1;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            op_q       <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            addr_q     <= addr_n;
            op_q       <= op_n;
            last_grant <= last_n;
            grant_id   <= gid_n;
            ack0       <= ack0_n;
            ack1       <= ack1_n;
        end
    end

    // Each state loads the counter with its length minus one on entry and leaves at zero.
    always_comb begin
        state_n = state;
        cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
        addr_n  = addr_q;
        op_n    = op_q;
        gid_n   = grant_id;
        last_n  = last_grant;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        case (state)
            S_IDLE: if (req0 || req1) begin
                state_n = S_START;
                addr_n  = win ? addr1 : addr0;
                op_n    = win ? op1 : op0;
                gid_n   = win;
                last_n  = win;
                ack0_n  = ~win;
                ack1_n  = win;
            end
            S_START: begin
                state_n = S_ADDR;
                cnt_n   = C_BIT;
            end
            S_ADDR: if (cnt == '0) begin
                state_n = S_CMD;
                cnt_n   = C_BIT;
            end
            S_CMD: if (cnt == '0) begin
                state_n = S_EXEC;
                cnt_n   = long_op ? C_LONG : C_SHORT;
            end
            S_EXEC: if (cnt == '0) begin
                state_n = S_GAP;
                cnt_n   = C_GAP;
            end
            S_GAP: if (cnt == '0) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
endmodule
